global_fetch_ctrl: RTL and testbench
====================================

GLOBAL_FETCH_CTRL -- requirements
Module: global_fetch_ctrl

Interface
REQ-001 Parameter DATA_W, 128, width of one buffer word and of the output stream.
REQ-002 Parameter ADDR_W, 32, width of all address and size ports, in word units.
REQ-003 Parameter DEPTH, 1024, number of words in the internal buffer; power of two.
REQ-004 Parameter NUM_REGIONS, 4, number of region descriptors (for example IFM, weight L1, weight L2); RSEL_W = clog2(NUM_REGIONS).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 load_phase  in  1  selects load mode (1) or fetch mode (0).
REQ-008 we_load  in  1  buffer write strobe.
REQ-009 wr_addr  in  ADDR_W  buffer write word address.
REQ-010 wr_data  in  DATA_W  buffer write data.
REQ-011 cfg_we  in  1  descriptor write strobe.
REQ-012 cfg_region  in  RSEL_W  descriptor index being written.
REQ-013 cfg_base  in  ADDR_W  region base word address.
REQ-014 cfg_size  in  ADDR_W  region length in words.
REQ-015 start  in  1  fetch request pulse.
REQ-016 start_region  in  RSEL_W  region to fetch.
REQ-017 repeat_cnt  in  8  pass count; 0 is treated as 1.
REQ-018 out_valid  out  1  stream data valid.
REQ-019 out_ready  in  1  consumer ready.
REQ-020 out_data  out  DATA_W  stream word.
REQ-021 out_last  out  1  final word of the current pass.
REQ-022 out_region  out  RSEL_W  region being streamed.
REQ-023 busy  out  1  fetch in progress.
REQ-024 done  out  1  one-cycle completion pulse.
REQ-025 err  out  1  sticky error flag.

Function
REQ-026 The buffer SHALL be DEPTH x DATA_W, indexed by addr[clog2(DEPTH)-1:0].
REQ-027 A write SHALL occur when we_load=1, load_phase=1 and state=IDLE; wr_addr>=DEPTH is dropped and sets err.
REQ-028 we_load=1 while busy SHALL be dropped and SHALL set err.
REQ-029 cfg_we SHALL update descriptor[cfg_region] in any state; an active fetch SHALL use the values latched at start.
REQ-030 FSM states SHALL be IDLE, FETCH and DONE.
REQ-031 IDLE->FETCH SHALL occur on start=1 with load_phase=0, latching base, size, region and max(repeat_cnt,1).
REQ-032 start while busy, or with load_phase=1, SHALL be ignored.
REQ-033 On start, if size=0, or base+size>DEPTH computed at ADDR_W+1 bits, the FSM SHALL go to DONE with no beats and, on the oversize case only, set err.
REQ-034 FETCH SHALL issue reads only when the 2-entry output FIFO has space after accounting for in-flight reads; read latency is 1 cycle.
REQ-035 With start sampled at edge k and out_ready=1, out_valid SHALL first be 1 after edge k+2; thereafter one beat SHALL be delivered per cycle.
REQ-036 A beat SHALL transfer when out_valid and out_ready are both 1.
REQ-037 out_data, out_last and out_region SHALL hold stable while out_valid=1 and out_ready=0.
REQ-038 The read pointer SHALL run base..base+size-1, then reload base for each remaining pass; total beats = size x passes.
REQ-039 out_last SHALL be 1 on word base+size-1 of every pass.
REQ-040 FETCH->DONE SHALL occur after the final handshake; DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-041 busy SHALL be 1 in FETCH and DONE, and 0 in IDLE.
REQ-042 err SHALL clear only on reset.

Reset
REQ-043 On reset=1 at an edge: state=IDLE, FIFO emptied, descriptors=0, out_valid=0, out_last=0, out_data=0, out_region=0, busy=0, done=0, err=0.
REQ-044 Reset mid-fetch SHALL abort with no further beats; buffer contents SHALL be retained.

Verification
REQ-045 Load words 0..7 with value i, set desc0={0,8}, start region0 repeat 1 with out_ready=1 -> 8 beats of 0..7 from edge k+2, out_last on 7, done at the cycle after the last beat.
REQ-046 desc1={4,3}, repeat 3, out_ready toggling 1/0 -> 9 beats 4,5,6 x3, out_last on each 6, data stable while stalled, no loss or duplication.
REQ-047 desc2={1020,8} with DEPTH=1024 -> no beats, err=1, done pulse, busy low afterwards.
REQ-048 size=0 -> done pulse, err=0, out_valid never 1; second start while busy is ignored (beat count unchanged).
REQ-049 we_load during FETCH -> buffer unchanged, err=1; reset asserted after 3 beats -> all outputs 0 next cycle, buffer readable with original data on refetch.

Source files
------------

// File: rtl/global_fetch_ctrl_if.sv
// Signal bundle for global_fetch_ctrl: buffer load, region descriptors, fetch start and output stream.
interface global_fetch_ctrl_if #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int NUM_REGIONS = 4
);
    localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    logic              load_phase;
    logic              we_load;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cfg_we;
    logic [RSEL_W-1:0] cfg_region;
    logic [ADDR_W-1:0] cfg_base;
    logic [ADDR_W-1:0] cfg_size;
    logic              start;
    logic [RSEL_W-1:0] start_region;
    logic [7:0]        repeat_cnt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [RSEL_W-1:0] out_region;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output load_phase, we_load, wr_addr, wr_data, cfg_we, cfg_region, cfg_base, cfg_size,
               start, start_region, repeat_cnt, out_ready,
        input  out_valid, out_data, out_last, out_region, busy, done, err
    );

    modport slave (
        input  load_phase, we_load, wr_addr, wr_data, cfg_we, cfg_region, cfg_base, cfg_size,
               start, start_region, repeat_cnt, out_ready,
        output out_valid, out_data, out_last, out_region, busy, done, err
    );
endinterface

// File: rtl/global_fetch_ctrl.sv
// Streams a descriptor-selected region of the on-chip buffer, repeated N passes, through a 2-entry output FIFO.
// state | meaning
// IDLE  | accepts buffer writes and start requests
// FETCH | issuing buffer reads and draining beats to the stream
// DONE  | one-cycle completion pulse, then back to IDLE
module global_fetch_ctrl #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int NUM_REGIONS = 4
) (
    input logic                clk,
    input logic                reset,
    global_fetch_ctrl_if.slave bus
);
    localparam int RSEL_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] desc_base [NUM_REGIONS];
    logic [ADDR_W-1:0] desc_size [NUM_REGIONS];

    logic [ADDR_W-1:0] base_q, last_addr_q, ptr;
    logic [RSEL_W-1:0] region_q;
    logic [7:0]        pass_left;
    logic              iss_done;
    logic              err_q;

    logic [DATA_W-1:0] rd_data;
    logic              rd_vld, rd_last, rd_fin;

    logic [DATA_W-1:0] f_data   [2];
    logic              f_last   [2];
    logic              f_fin    [2];
    logic [RSEL_W-1:0] f_region [2];
    logic              f_wp, f_rp;
    logic [1:0]        f_cnt;

    logic [ADDR_W-1:0] sel_base, sel_size;
    logic [ADDR_W:0]   end_x;
    logic [2:0]        occ;
    logic start_ok, size_zero, oversize, pop, rd_en, iss_last, iss_fin;
    logic addr_oob, wr_hit, wr_err;

    assign sel_base  = desc_base[bus.start_region];
    assign sel_size  = desc_size[bus.start_region];
    assign end_x     = {1'b0, sel_base} + {1'b0, sel_size};
    assign size_zero = (sel_size == '0);
    assign oversize  = (end_x > DEPTH_X);
    assign start_ok  = bus.start && !bus.load_phase && (state == IDLE);
    assign pop       = (f_cnt != 2'd0) && bus.out_ready;
    assign occ       = {1'b0, f_cnt} + {2'b00, rd_vld};
    assign iss_last  = (ptr == last_addr_q);
    assign iss_fin   = iss_last && (pass_left == 8'd1);
    assign addr_oob  = ({1'b0, bus.wr_addr} >= DEPTH_X);
    assign wr_hit    = bus.we_load && bus.load_phase && (state == IDLE) && !addr_oob && !reset;
    assign wr_err    = bus.we_load && ((state != IDLE) || (bus.load_phase && addr_oob));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = (size_zero || oversize) ? DONE : FETCH;
            FETCH:   if (pop && f_fin[f_rp]) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reads are issued only if the FIFO can still absorb them once the in-flight read lands.
    always_comb begin
        bus.busy       = (state != IDLE);
        bus.done       = (state == DONE);
        bus.err        = err_q;
        bus.out_valid  = (f_cnt != 2'd0);
        bus.out_data   = f_data[f_rp];
        bus.out_last   = f_last[f_rp];
        bus.out_region = f_region[f_rp];
        rd_en          = (state == FETCH) && !iss_done && (occ < (pop ? 3'd3 : 3'd2));
    end

    always_ff @(posedge clk) begin
        if (wr_hit) mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
        if (rd_en)  rd_data <= mem[ptr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                desc_base[i] <= '0;
                desc_size[i] <= '0;
            end
        end else if (bus.cfg_we) begin
            desc_base[bus.cfg_region] <= bus.cfg_base;
            desc_size[bus.cfg_region] <= bus.cfg_size;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q      <= '0;
            last_addr_q <= '0;
            ptr         <= '0;
            region_q    <= '0;
            pass_left   <= '0;
            iss_done    <= 1'b1;
            err_q       <= 1'b0;
            rd_vld      <= 1'b0;
            rd_last     <= 1'b0;
            rd_fin      <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q      <= sel_base;
                last_addr_q <= sel_base + sel_size - ADDR_W'(1);
                ptr         <= sel_base;
                region_q    <= bus.start_region;
                pass_left   <= (bus.repeat_cnt == 8'd0) ? 8'd1 : bus.repeat_cnt;
                iss_done    <= size_zero || oversize;
            end else if (rd_en) begin
                if (iss_last) begin
                    ptr <= base_q;
                    if (pass_left == 8'd1) iss_done  <= 1'b1;
                    else                   pass_left <= pass_left - 8'd1;
                end else begin
                    ptr <= ptr + ADDR_W'(1);
                end
            end
            if (wr_err || (start_ok && oversize)) err_q <= 1'b1;
            rd_vld  <= rd_en;
            rd_last <= iss_last;
            rd_fin  <= iss_fin;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                f_data[i]   <= '0;
                f_last[i]   <= 1'b0;
                f_fin[i]    <= 1'b0;
                f_region[i] <= '0;
            end
            f_wp  <= 1'b0;
            f_rp  <= 1'b0;
            f_cnt <= 2'd0;
        end else begin
            if (rd_vld) begin
                f_data[f_wp]   <= rd_data;
                f_last[f_wp]   <= rd_last;
                f_fin[f_wp]    <= rd_fin;
                f_region[f_wp] <= region_q;
                f_wp           <= ~f_wp;
            end
            if (pop) f_rp <= ~f_rp;
            f_cnt <= f_cnt + 2'(rd_vld) - 2'(pop);
        end
    end
endmodule

// File: tb/tb_global_fetch_ctrl.sv
// Randomized self-checking bench for global_fetch_ctrl against a word-level buffer/descriptor model.
module tb_global_fetch_ctrl;
    localparam int DATA_W = 128, ADDR_W = 32, DEPTH = 1024, NUM_REGIONS = 4, RSEL_W = 2;

    logic clk = 1'b0;
    logic reset;

    global_fetch_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGIONS(NUM_REGIONS)) bus ();
    global_fetch_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_REGIONS(NUM_REGIONS))
        dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [RSEL_W-1:0] region;
    } beat_t;

    beat_t             obs[$];
    beat_t             exp_q[$];
    logic [DATA_W-1:0] model_mem [DEPTH];
    int checks = 0, failures = 0;
    int cyc_cnt = 0;
    int done_pulses = 0, done_cyc = 0, last_beat_cyc = 0, first_valid_cyc = -1;
    int valid_cycles = 0, stall_err = 0;
    int ready_mode = 0;
    beat_t prev;
    logic  prev_stall = 1'b0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (bus.out_ready === 1'b1) ? 1'b0 : 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Stream observer: records handshakes, done pulses, and any change while stalled.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            valid_cycles++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc_cnt;
            if (prev_stall && ({bus.out_data, bus.out_last, bus.out_region} !== prev)) stall_err++;
        end else if (prev_stall) begin
            stall_err++;
        end
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            obs.push_back({bus.out_data, bus.out_last, bus.out_region});
            last_beat_cyc = cyc_cnt;
        end
        if (bus.done === 1'b1) begin
            done_pulses++;
            done_cyc = cyc_cnt;
        end
        prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
        prev       = {bus.out_data, bus.out_last, bus.out_region};
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.load_phase = 1'b0; bus.we_load = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.cfg_we = 1'b0; bus.cfg_region = '0; bus.cfg_base = '0; bus.cfg_size = '0;
        bus.start = 1'b0; bus.start_region = '0; bus.repeat_cnt = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        obs.delete(); exp_q.delete();
        done_pulses = 0; first_valid_cyc = -1; valid_cycles = 0; stall_err = 0;
    endtask

    task automatic load_word(input int a, input logic [DATA_W-1:0] d);
        bus.load_phase = 1'b1; bus.we_load = 1'b1; bus.wr_addr = ADDR_W'(a); bus.wr_data = d;
        step(1);
        bus.we_load = 1'b0;
        if (a < DEPTH) model_mem[a] = d;
    endtask

    task automatic set_desc(input int r, input int b, input int s);
        bus.cfg_we = 1'b1; bus.cfg_region = RSEL_W'(r); bus.cfg_base = ADDR_W'(b); bus.cfg_size = ADDR_W'(s);
        step(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic start_fetch(input int r, input int rep, output int t0);
        bus.load_phase = 1'b0; bus.start = 1'b1; bus.start_region = RSEL_W'(r); bus.repeat_cnt = 8'(rep);
        t0 = cyc_cnt;
        step(1);
        bus.start = 1'b0;
    endtask

    task automatic build_exp(input int b, input int s, input int passes, input int r);
        for (int p = 0; p < passes; p++)
            for (int a = b; a < b + s; a++)
                exp_q.push_back({model_mem[a], (a == b + s - 1), RSEL_W'(r)});
    endtask

    task automatic wait_done(input int max_cyc, output bit timed_out);
        int n = 0;
        while (done_pulses == 0 && n < max_cyc) begin
            step(1);
            n++;
        end
        timed_out = (done_pulses == 0);
        step(2);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        step(2);
        checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.err} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.out_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.out_data); end
        checks++;
        if (bus.out_region !== '0) begin failures++; $display("FAIL reset_region got=%0d exp=0", bus.out_region); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        int t0; bit to;
        do_reset();
        for (int i = 0; i < 8; i++) load_word(i, DATA_W'(i));
        set_desc(0, 0, 8);
        clear_obs();
        build_exp(0, 8, 1, 0);
        ready_mode = 0;
        start_fetch(0, 1, t0);
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no_done exp=done"); end
        checks++;
        if (first_valid_cyc - t0 != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", first_valid_cyc - t0); end
        checks++;
        if (last_beat_cyc - first_valid_cyc != 7) begin
            failures++; $display("FAIL basic_throughput got=%0d exp=7", last_beat_cyc - first_valid_cyc);
        end
        checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL basic_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL basic_done_pulses got=%0d exp=1", done_pulses); end
        checks++;
        if (done_cyc != last_beat_cyc + 1) begin failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, last_beat_cyc + 1); end
        checks++; if ({bus.busy, bus.err} !== 2'b00) begin failures++; $display("FAIL basic_busy_err got=%b exp=00", {bus.busy, bus.err}); end
    endtask

    task automatic test_repeat_stall();
        int t0; bit to;
        do_reset();
        set_desc(1, 4, 3);
        clear_obs();
        build_exp(4, 3, 3, 1);
        ready_mode = 1;
        start_fetch(1, 3, t0);
        step(3);
        set_desc(1, 0, 2);
        wait_done(200, to);
        checks++; if (to) begin failures++; $display("FAIL repeat_timeout got=no_done exp=done"); end
        checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL repeat_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL repeat_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL repeat_stall_stable got=%0d exp=0", stall_err); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL repeat_done_pulses got=%0d exp=1", done_pulses); end
    endtask

    task automatic test_zero_and_restart();
        int t0; bit to;
        do_reset();
        set_desc(3, 0, 0);
        clear_obs();
        start_fetch(3, 5, t0);
        wait_done(20, to);
        checks++; if (to) begin failures++; $display("FAIL zero_timeout got=no_done exp=done"); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", done_pulses); end
        checks++; if (valid_cycles != 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", valid_cycles); end
        checks++; if ({bus.busy, bus.err} !== 2'b00) begin failures++; $display("FAIL zero_busy_err got=%b exp=00", {bus.busy, bus.err}); end
        set_desc(0, 0, 8);
        clear_obs();
        build_exp(0, 8, 1, 0);
        ready_mode = 2;
        start_fetch(0, 1, t0);
        step(2);
        start_fetch(0, 4, t0);
        wait_done(200, to);
        checks++; if (to) begin failures++; $display("FAIL restart_timeout got=no_done exp=done"); end
        checks++; if (obs.size() != 8) begin failures++; $display("FAIL restart_count got=%0d exp=8", obs.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL restart_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL restart_stall_stable got=%0d exp=0", stall_err); end
        bus.load_phase = 1'b1; bus.start = 1'b1; bus.start_region = '0;
        step(1);
        bus.start = 1'b0;
        step(3);
        checks++;
        if (bus.busy !== 1'b0 || done_pulses != 1) begin
            failures++; $display("FAIL start_in_load got_busy=%b got_done=%0d exp_busy=0 exp_done=1", bus.busy, done_pulses);
        end
    endtask

    task automatic test_oversize();
        int t0; bit to;
        do_reset();
        for (int a = DEPTH - 8; a < DEPTH; a++) load_word(a, {$urandom, $urandom, $urandom, $urandom});
        set_desc(2, DEPTH - 8, 8);
        clear_obs();
        build_exp(DEPTH - 8, 8, 1, 2);
        ready_mode = 0;
        start_fetch(2, 1, t0);
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL edge_timeout got=no_done exp=done"); end
        checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL edge_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL edge_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL edge_err got=%b exp=0", bus.err); end
        set_desc(2, DEPTH - 4, 8);
        clear_obs();
        start_fetch(2, 1, t0);
        wait_done(20, to);
        checks++; if (to) begin failures++; $display("FAIL over_timeout got=no_done exp=done"); end
        checks++; if (valid_cycles != 0) begin failures++; $display("FAIL over_valid got=%0d exp=0", valid_cycles); end
        checks++; if (done_pulses != 1) begin failures++; $display("FAIL over_done_pulses got=%0d exp=1", done_pulses); end
        checks++; if ({bus.busy, bus.err} !== 2'b01) begin failures++; $display("FAIL over_busy_err got=%b exp=01", {bus.busy, bus.err}); end
    endtask

    task automatic test_bad_write();
        int t0; bit to;
        do_reset();
        load_word(DEPTH + 3, {4{32'hdead_beef}});
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL badwr_err got=%b exp=1", bus.err); end
        set_desc(0, 0, 8);
        clear_obs();
        build_exp(0, 8, 1, 0);
        ready_mode = 0;
        start_fetch(0, 1, t0);
        wait_done(100, to);
        checks++; if (to) begin failures++; $display("FAIL badwr_timeout got=no_done exp=done"); end
        checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL badwr_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL badwr_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_busy_write_and_reset();
        int t0, n, k; bit to;
        do_reset();
        set_desc(0, 0, 8);
        clear_obs();
        build_exp(0, 8, 1, 0);
        ready_mode = 0;
        start_fetch(0, 1, t0);
        bus.load_phase = 1'b1; bus.we_load = 1'b1; bus.wr_addr = ADDR_W'(2); bus.wr_data = DATA_W'(999);
        step(1);
        bus.we_load = 1'b0; bus.load_phase = 1'b0;
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL busywr_err got=%b exp=1", bus.err); end
        k = 0;
        while (obs.size() < 3 && k < 50) begin step(1); k++; end
        checks++; if (obs.size() < 3) begin failures++; $display("FAIL midreset_wait got=%0d exp=3", obs.size()); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_last, bus.busy, bus.done, bus.err} !== 5'b0 || bus.out_data !== '0 || bus.out_region !== '0) begin
            failures++;
            $display("FAIL midreset_outputs got=%b data=%h region=%0d exp=0", {bus.out_valid, bus.out_last, bus.busy, bus.done, bus.err},
                     bus.out_data, bus.out_region);
        end
        n = obs.size();
        step(6);
        checks++; if (obs.size() != n) begin failures++; $display("FAIL midreset_beats got=%0d exp=%0d", obs.size(), n); end
        foreach (obs[i]) if (i < exp_q.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL midreset_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
        clear_obs();
        start_fetch(0, 1, t0);
        wait_done(20, to);
        checks++;
        if (to || valid_cycles != 0) begin failures++; $display("FAIL desc_cleared got_valid=%0d exp_valid=0 timeout=%0d", valid_cycles, to); end
        set_desc(0, 0, 8);
        clear_obs();
        build_exp(0, 8, 1, 0);
        start_fetch(0, 1, t0);
        wait_done(100, to);
        checks++; if (obs.size() != exp_q.size()) begin failures++; $display("FAIL refetch_count got=%0d exp=%0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs.size()) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL refetch_beat%0d got=%h exp=%h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int t0, r, b, s, rep; bit to;
        do_reset();
        for (int a = 0; a < 64; a++) load_word(a, {$urandom, $urandom, $urandom, $urandom});
        for (int it = 0; it < 8; it++) begin
            r   = $urandom_range(0, NUM_REGIONS - 1);
            s   = $urandom_range(1, 8);
            b   = $urandom_range(0, 64 - s);
            rep = $urandom_range(0, 3);
            set_desc(r, b, s);
            clear_obs();
            build_exp(b, s, (rep == 0) ? 1 : rep, r);
            ready_mode = 2;
            start_fetch(r, rep, t0);
            wait_done(400, to);
            checks++; if (to) begin failures++; $display("FAIL rand%0d_timeout got=no_done exp=done", it); end
            checks++;
            if (obs.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, obs.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs.size()) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_beat%0d got=%h exp=%h", it, i, obs[i], exp_q[i]); end
            end
            checks++; if (stall_err != 0) begin failures++; $display("FAIL rand%0d_stall_stable got=%0d exp=0", it, stall_err); end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_basic();
        test_repeat_stall();
        test_zero_and_restart();
        test_oversize();
        test_bad_write();
        test_busy_write_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
